// File: rtl/axi4l_master.sv
// axi4l_master: single-outstanding AXI4-Lite initiator (AW/W/AR/R, no B).
// Turns a valid/ready request port into one AXI transaction with timeout.
module axi4l_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_AR,
    S_RD,
    S_RESP
  } state_t;

  // Counter is wide enough to hold TIMEOUT+1 without wrapping.
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  state_t            r_state;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [CW-1:0]     r_cnt;

  logic              w_busy;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_tmo;
  logic              w_aw_ok;
  logic              w_w_ok;
  logic              w_pend;
  logic              w_abort;

  assign w_busy    = (r_state == S_WR) || (r_state == S_AR) ||
                     (r_state == S_RD);
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_tmo     = (TIMEOUT != 0) && w_busy && (w_cnt_nxt >= TO);

  // A channel counts as done once its handshake is seen this cycle or earlier.
  assign w_aw_ok = !r_awvalid || m_axi_awready;
  assign w_w_ok  = !r_wvalid  || m_axi_wready;

  // Still waiting on something this cycle; a handshake beats the timeout.
  always_comb begin
    w_pend = 1'b0;
    unique case (1'b1)
      (r_state == S_WR): w_pend = !(w_aw_ok && w_w_ok);
      (r_state == S_AR): w_pend = !m_axi_arready;
      (r_state == S_RD): w_pend = !m_axi_rvalid;
      default:           w_pend = 1'b0;
    endcase
  end

  assign w_abort = w_tmo && w_pend;

  // Transaction FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_cnt       <= '0;
            if (req_we) begin
              r_state   <= S_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_WR: begin
          r_cnt <= w_cnt_nxt;
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        S_AR: begin
          r_cnt <= w_cnt_nxt;
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD;
          end
        end
        S_RD: begin
          r_cnt <= w_cnt_nxt;
          if (m_axi_rvalid) begin
            r_rready    <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= m_axi_rdata;
            r_rsp_err   <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Timeout abort overrides whatever the state branch chose.
      if (w_abort) begin
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
        r_state     <= S_RESP;
      end
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
